hilo_mdu: RTL

//  Execute-stage HI/LO register file with an iterative multiply/divide unit.

---
 rtl/hilo_mdu.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/hilo_mdu.sv
// hilo_mdu -- execute-stage HI/LO register file with an iterative multiply/divide unit.
//
// Holds HI/LO for MFHI/MFLO. It accepts MTHI/MTLO writes through hilo_we
// (10 = HI, 01 = LO, 11 = both). It runs MULT/MULTU/DIV/DIVU one bit per cycle
// and raises busy so the pipeline stalls while an operation is in flight.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   hilo_we   [1]=write HI, [0]=write LO from wdata (dropped while busy)
//   wdata     MTHI/MTLO source
//   md_start  start mult/div (sampled only while idle)
//   md_op     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a     multiplicand / dividend
//   src_b     multiplier / divisor
//   flush     abort an in-flight operation; HI/LO keep their old values
//   hi, lo    registered HI/LO
//   busy      operation in flight
//   done      one-cycle pulse after mult/div wrote HI/LO
//
// Build option
//   HILO_FAST_MULT_EN : MULT/MULTU complete in a single cycle. Their result is
//                       written on the start edge and busy stays low. DIV is
//                       unchanged.
module hilo_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_dw(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_op_a, r_op_b, r_raw_a;
    logic               r_neg_q, r_neg_r;
    logic [WIDTH-1:0]   r_acc_hi, r_acc_lo;

    logic               w_start, w_last, w_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_mul_sum, w_div_shift;
    logic [WIDTH-1:0]   w_mul_hi, w_mul_lo, w_div_hi, w_div_lo;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_acc_hi_nxt, w_acc_lo_nxt, w_res_hi, w_res_lo;

    // A start in the same cycle as flush is discarded.
    assign w_start  = (r_state == S_IDLE) && md_start && !flush;
    assign w_last   = (r_cnt == LAST);

    // Signed ops work on magnitudes. Signs are reapplied on the final write.
    assign w_signed = ~md_op[0];
    assign w_a_neg  = w_signed & src_a[WIDTH-1];
    assign w_b_neg  = w_signed & src_b[WIDTH-1];
    assign w_mag_a  = cond_neg(src_a, w_a_neg);
    assign w_mag_b  = cond_neg(src_b, w_b_neg);

`ifdef HILO_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = cond_neg_dw({{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b},
                                     w_a_neg ^ w_b_neg);
`endif

    // Shift-add step: the multiplier sits in acc_lo and is consumed LSB first.
    // The partial product enters acc_hi and shifts down into acc_lo.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_op_a} : '0);
    assign w_mul_hi    = w_mul_sum[WIDTH:1];
    assign w_mul_lo    = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

    // Restoring step: the remainder is in acc_hi, and the dividend shifts out
    // of acc_lo while quotient bits shift in.
    // The shifted remainder is < 2*divisor, so a subtraction that succeeds fits in WIDTH bits.
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_op_b});
    assign w_div_hi    = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_op_b) : w_div_shift[WIDTH-1:0];
    assign w_div_lo    = {r_acc_lo[WIDTH-2:0], w_div_ge};

    always_comb begin
        w_acc_hi_nxt = w_div_hi;
        w_acc_lo_nxt = w_div_lo;
        w_res_hi     = cond_neg(w_div_hi, r_neg_r);
        w_res_lo     = cond_neg(w_div_lo, r_neg_q);
        if (r_state == S_MUL) begin
            w_acc_hi_nxt         = w_mul_hi;
            w_acc_lo_nxt         = w_mul_lo;
            {w_res_hi, w_res_lo} = cond_neg_dw({w_mul_hi, w_mul_lo}, r_neg_q);
        end else if (r_op_b == '0) begin
            // Divide by zero: all-ones quotient, and the dividend as remainder.
            w_res_hi = r_raw_a;
            w_res_lo = '1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
`ifdef HILO_FAST_MULT_EN
                    w_state_nxt = md_op[1] ? S_DIV : S_IDLE;
`else
                    w_state_nxt = md_op[1] ? S_DIV : S_MUL;
`endif
                end
            end
            S_MUL, S_DIV: if (flush || w_last) w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // HI/LO, done pulse and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            r_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
                if (hilo_we[1]) hi <= wdata;
                if (hilo_we[0]) lo <= wdata;
`ifdef HILO_FAST_MULT_EN
                if (w_start && !md_op[1]) begin
                    hi   <= w_fast_prod[2*WIDTH-1:WIDTH];
                    lo   <= w_fast_prod[WIDTH-1:0];
                    done <= 1'b1;
                end
`endif
            end else if (flush) begin
                r_cnt <= '0;
            end else if (w_last) begin
                r_cnt <= '0;
                hi    <= w_res_hi;
                lo    <= w_res_lo;
                done  <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Operand latches and working accumulator
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_op_a   <= w_mag_a;
            r_op_b   <= w_mag_b;
            r_raw_a  <= src_a;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_acc_hi <= '0;
            r_acc_lo <= md_op[1] ? w_mag_a : w_mag_b;
        end else if (busy) begin
            r_acc_hi <= w_acc_hi_nxt;
            r_acc_lo <= w_acc_lo_nxt;
        end
    end

endmodule
